// File: rtl/card_game_ctrl.sv
// Memory-card game logic: LFSR shuffle, cursor, pair reveal/compare, mismatch hold.
// Optional move counter enabled by defining MOVE_COUNTER_EN.
module card_game_ctrl #(
  parameter int          HOLD_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [15:0] reg_card,
  output logic [63:0] pos_flat,
  output logic [3:0]  cursor,
  output logic [3:0]  match_count,
  output logic        game_over,
  output logic [7:0]  moves
);

  typedef enum logic [2:0] {
    SHUFFLE, PICK1, PICK2, CHECK, SHOW, DONE
  } state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

  state_t      state, state_n;
  logic [15:0] lfsr, lfsr_n;
  logic [3:0]  step, step_n;
  logic [3:0]  pos [16];
  logic [3:0]  pos_n [16];
  logic [3:0]  first, first_n;
  logic [3:0]  second, second_n;
  logic [7:0]  hold, hold_n;
  logic [15:0] card_n;
  logic [3:0]  cursor_n;
  logic [3:0]  match_n;
  logic        over_n;
  logic [3:0]  under;
  logic        pick;

  always_comb begin
    under = 4'd0;
    for (int i = 0; i < 16; i++)
      if (pos[i] == cursor) under = 4'(i);
  end

  always_comb begin
    for (int i = 0; i < 16; i++)
      pos_flat[4*i +: 4] = pos[i];
  end

  // a select only takes effect on a face-down card
  assign pick = btn_sel && !reg_card[under];

  always_comb begin
    cursor_n = cursor;
    if (state != SHUFFLE && !btn_sel) begin
      if (btn_up)
        cursor_n = {cursor[3:2] - 2'd1, cursor[1:0]};
      else if (btn_down)
        cursor_n = {cursor[3:2] + 2'd1, cursor[1:0]};
      else if (btn_left)
        cursor_n = {cursor[3:2], cursor[1:0] - 2'd1};
      else if (btn_right)
        cursor_n = {cursor[3:2], cursor[1:0] + 2'd1};
    end
  end

  always_comb begin
    state_n  = state;
    lfsr_n   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    step_n   = step;
    pos_n    = pos;
    first_n  = first;
    second_n = second;
    hold_n   = hold;
    card_n   = reg_card;
    match_n  = match_count;
    over_n   = game_over;
    unique case (state)
      SHUFFLE: begin
        pos_n[step]      = pos[lfsr[3:0]];
        pos_n[lfsr[3:0]] = pos[step];
        step_n = step + 4'd1;
        if (step == 4'd15) state_n = PICK1;
      end
      PICK1: if (pick) begin
        card_n[under] = 1'b1;
        first_n = under;
        state_n = PICK2;
      end
      PICK2: if (pick) begin
        card_n[under] = 1'b1;
        second_n = under;
        state_n = CHECK;
      end
      CHECK: begin
        if ((first ^ second) == 4'd1) begin
          match_n = match_count + 4'd1;
          if (match_count == 4'd7) begin
            state_n = DONE;
            over_n  = 1'b1;
            card_n  = 16'hFFFF;
          end else begin
            state_n = PICK1;
          end
        end else begin
          hold_n  = 8'd0;
          state_n = SHOW;
        end
      end
      SHOW: if (frame_tick) begin
        if (hold + 8'd1 == HOLD) begin
          card_n[first]  = 1'b0;
          card_n[second] = 1'b0;
          state_n = PICK1;
        end else begin
          hold_n = hold + 8'd1;
        end
      end
      DONE: begin
        card_n = 16'hFFFF;
        if (btn_sel) begin
          card_n  = 16'h0000;
          match_n = 4'd0;
          over_n  = 1'b0;
          step_n  = 4'd0;
          state_n = SHUFFLE;
        end
      end
      default: state_n = SHUFFLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SHUFFLE;
      lfsr        <= LFSR_SEED;
      step        <= 4'd0;
      first       <= 4'd0;
      second      <= 4'd0;
      hold        <= 8'd0;
      reg_card    <= 16'h0000;
      cursor      <= 4'd0;
      match_count <= 4'd0;
      game_over   <= 1'b0;
      for (int i = 0; i < 16; i++) pos[i] <= 4'(i);
    end else begin
      state       <= state_n;
      lfsr        <= lfsr_n;
      step        <= step_n;
      first       <= first_n;
      second      <= second_n;
      hold        <= hold_n;
      reg_card    <= card_n;
      cursor      <= cursor_n;
      match_count <= match_n;
      game_over   <= over_n;
      pos         <= pos_n;
    end
  end

`ifdef MOVE_COUNTER_EN
  logic [7:0] mv_n;

  always_comb begin
    mv_n = moves;
    if (state == PICK2 && pick && moves != 8'hFF)
      mv_n = moves + 8'd1;
    else if (state == DONE && btn_sel)
      mv_n = 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) moves <= 8'd0;
    else       moves <= mv_n;
  end
`else
  assign moves = 8'd0;
`endif

endmodule

// File: tb/tb_card_game_ctrl.sv
// Scoreboard bench for card_game_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_card_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [15:0] reg_card;
  logic [63:0] pos_flat;
  logic [3:0]  cursor;
  logic [3:0]  match_count;
  logic        game_over;
  logic [7:0]  moves;

  card_game_ctrl #(.HOLD_FRAMES(60), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel),
    .reg_card(reg_card), .pos_flat(pos_flat), .cursor(cursor),
    .match_count(match_count), .game_over(game_over), .moves(moves)
  );

  always #5 clk = ~clk;

`ifdef MOVE_COUNTER_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  localparam logic [5:0] SEL = 6'd1, UP = 6'd2, DN = 6'd4;
  localparam logic [5:0] LT = 6'd8, RT = 6'd16, FRM = 6'd32;
  localparam int F_CARD = 0, F_CUR = 1, F_MATCH = 2;
  localparam int F_OVER = 3, F_MOVES = 4, F_POS = 5, F_PERM = 6;

  typedef struct {
    int          f;
    logic [63:0] v;
    int          due;
    string       nm;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] cur;

  always @(posedge clk) cyc++;

  function automatic logic perm_ok();
    logic [15:0] seen;
    seen = 16'h0;
    for (int i = 0; i < 16; i++) seen[pos_flat[4*i +: 4]] = 1'b1;
    return seen == 16'hFFFF;
  endfunction

  function automatic logic [63:0] actual(input int f);
    case (f)
      F_CARD:  return 64'(reg_card);
      F_CUR:   return 64'(cursor);
      F_MATCH: return 64'(match_count);
      F_OVER:  return 64'(game_over);
      F_MOVES: return 64'(moves);
      F_POS:   return pos_flat;
      F_PERM:  return 64'(perm_ok());
      default: return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] a;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      a = actual(e.f);
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s actual=%h required=%h", e.nm, a, e.v);
      end
    end
  end

  task automatic expect_v(input int f, input logic [63:0] v,
                          input string nm);
    exp_t e;
    e.f = f; e.v = v; e.due = cyc; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] m);
    {frame_tick, btn_right, btn_left, btn_down, btn_up, btn_sel} = m;
    tick();
    {frame_tick, btn_right, btn_left, btn_down, btn_up, btn_sel} = 6'd0;
  endtask

  task automatic navigate(input int c);
    logic [3:0] t;
    t = pos_flat[4*c +: 4];
    while (cur[3:2] != t[3:2]) begin
      press(DN);
      cur[3:2] = cur[3:2] + 2'd1;
    end
    while (cur[1:0] != t[1:0]) begin
      press(RT);
      cur[1:0] = cur[1:0] + 2'd1;
    end
    expect_v(F_CUR, 64'(cur), "nav_cursor");
  endtask

  task automatic select(input int c);
    navigate(c);
    press(SEL);
  endtask

  task automatic expect_reset(input string nm);
    expect_v(F_CARD, 64'h0, {nm, "_card"});
    expect_v(F_CUR, 64'h0, {nm, "_cursor"});
    expect_v(F_MATCH, 64'h0, {nm, "_match"});
    expect_v(F_OVER, 64'h0, {nm, "_over"});
    expect_v(F_MOVES, 64'h0, {nm, "_moves"});
    expect_v(F_POS, 64'hFEDCBA9876543210, {nm, "_pos"});
  endtask

  initial begin
    reset = 1'b1;
    {frame_tick, btn_right, btn_left, btn_down, btn_up, btn_sel} = 6'd0;
    cur = 4'd0;
    tick(); tick();
    expect_reset("reset");
    tick();
    reset = 1'b0;

    // 16 shuffle cycles; a button inside them must be ignored
    tick(); tick();
    press(RT);
    repeat (13) tick();
    expect_v(F_PERM, 64'h1, "shuffle_perm");
    expect_v(F_CUR, 64'h0, "shuffle_cursor");
    expect_v(F_CARD, 64'h0, "shuffle_card");

    press(LT);      expect_v(F_CUR, 64'd3, "left_wrap");
    press(UP);      expect_v(F_CUR, 64'd15, "up_wrap");
    press(DN);      expect_v(F_CUR, 64'd3, "down_wrap");
    press(UP | RT); expect_v(F_CUR, 64'd15, "up_over_right");
    press(RT);      expect_v(F_CUR, 64'd12, "right_wrap");
    press(DN);      expect_v(F_CUR, 64'd0, "down_wrap2");
    cur = 4'd0;

    select(0); expect_v(F_CARD, 64'h0001, "pick_a");
    select(1); expect_v(F_CARD, 64'h0003, "pick_b");
    expect_v(F_MATCH, 64'd0, "check_cycle_match");
    tick();
    expect_v(F_MATCH, 64'd1, "match_ab");
    expect_v(F_CARD, 64'h0003, "match_ab_card");

    select(0); expect_v(F_CARD, 64'h0003, "faceup_ignored");
    select(2); expect_v(F_CARD, 64'h0007, "pick_c");
    select(4); expect_v(F_CARD, 64'h0017, "pick_e");
    tick();
    select(6); expect_v(F_CARD, 64'h0017, "sel_in_show");
    repeat (59) begin
      press(FRM);
      tick();
    end
    expect_v(F_CARD, 64'h0017, "hold_59");
    press(FRM);
    expect_v(F_CARD, 64'h0003, "hold_60_clear");
    expect_v(F_MATCH, 64'd1, "mismatch_match");

    select(2); expect_v(F_CARD, 64'h0007, "rereveal_c");
    select(3); expect_v(F_CARD, 64'h000F, "pick_d");
    tick();
    expect_v(F_MATCH, 64'd2, "match_cd");
    expect_v(F_MOVES, MC ? 64'd3 : 64'd0, "moves_3");

    for (int k = 2; k < 8; k++) begin
      select(2 * k);
      select(2 * k + 1);
      tick();
      expect_v(F_MATCH, 64'(k + 1), "match_pair");
    end
    expect_v(F_OVER, 64'h1, "game_over");
    expect_v(F_CARD, 64'hFFFF, "done_card");
    expect_v(F_MOVES, MC ? 64'd9 : 64'd0, "moves_9");

    press(SEL);
    expect_v(F_CARD, 64'h0, "restart_card");
    expect_v(F_MATCH, 64'h0, "restart_match");
    expect_v(F_OVER, 64'h0, "restart_over");
    expect_v(F_MOVES, 64'h0, "restart_moves");
    repeat (15) tick();
    press(LT);
    expect_v(F_CUR, 64'(cur), "reshuffle_busy");
    press(LT);
    cur[1:0] = cur[1:0] - 2'd1;
    expect_v(F_CUR, 64'(cur), "reshuffle_done");
    expect_v(F_PERM, 64'h1, "reshuffle_perm");

    select(0);
    select(2);
    tick();
    expect_v(F_CARD, 64'h0005, "show_ac");
    @(posedge clk);
    #2;
    reset = 1'b1;
    cur = 4'd0;
    expect_reset("async_reset");
    tick();
    reset = 1'b0;

    repeat (4) tick();
    if (sbq.size() > 0) begin
      $display("FAIL drain pending=%0d required=0", sbq.size());
      errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
